// File: rtl/main_memory_responder_pkg.sv
// rtl/main_memory_responder_pkg.sv - shared memory-interface message codes
package main_memory_responder_pkg;

    localparam int MSG_CODE_BITS = 4;

    localparam logic [MSG_CODE_BITS-1:0] NO_REQ   = 4'd0;
    localparam logic [MSG_CODE_BITS-1:0] WB_REQ   = 4'd2;
    localparam logic [MSG_CODE_BITS-1:0] R_REQ    = 4'd3;
    localparam logic [MSG_CODE_BITS-1:0] FLUSH    = 4'd4;
    localparam logic [MSG_CODE_BITS-1:0] MEM_RESP = 4'd8;

endpackage

// File: rtl/main_memory_responder_ram.sv
// rtl/main_memory_responder_ram.sv - single-port word RAM with synchronous read/write
module single_port_word_ram #(
    parameter int INDEX_BITS = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<INDEX_BITS)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents are deliberately left out of reset so they survive it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - fixed-latency main memory model answering read/write-back requests
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4,
    parameter int INDEX_BITS    = 10,
    parameter int LATENCY       = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MSG_BITS-1:0]      interface2mem_msg,
    input  logic [ADDRESS_WIDTH-1:0] interface2mem_address,
    input  logic [DATA_WIDTH-1:0]    interface2mem_data,
    output logic [MSG_BITS-1:0]      mem2interface_msg,
    output logic [ADDRESS_WIDTH-1:0] mem2interface_address,
    output logic [DATA_WIDTH-1:0]    mem2interface_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    localparam logic [MSG_BITS-1:0] C_NO_REQ   = MSG_BITS'(NO_REQ);
    localparam logic [MSG_BITS-1:0] C_WB_REQ   = MSG_BITS'(WB_REQ);
    localparam logic [MSG_BITS-1:0] C_R_REQ    = MSG_BITS'(R_REQ);
    localparam logic [MSG_BITS-1:0] C_MEM_RESP = MSG_BITS'(MEM_RESP);
    localparam logic [3:0]          CNT_LOAD   = 4'(LATENCY - 1);

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     op_write_q, op_write_d;
    logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]    req_data_q, req_data_d;
    logic [MSG_BITS-1:0]      msg_q, msg_d;
    logic [ADDRESS_WIDTH-1:0] resp_addr_q, resp_addr_d;
    logic                     resp_rd_q, resp_rd_d;

    logic                     in_req, in_write, fire;
    logic                     cur_write;
    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0]    cur_data;
    logic [DATA_WIDTH-1:0]    ram_rdata;

    assign in_write = (interface2mem_msg == C_WB_REQ);
    assign in_req   = (interface2mem_msg == C_R_REQ) || in_write;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        fire       = 1'b0;
        cur_write  = op_write_q;
        cur_addr   = req_addr_q;
        cur_data   = req_data_q;
        case (state_q)
            ST_IDLE: begin
                // With LATENCY==1 the RAM is accessed on the accept edge, so use the live inputs.
                cur_write = in_write;
                cur_addr  = interface2mem_address;
                cur_data  = interface2mem_data;
                if (in_req) begin
                    op_write_d = in_write;
                    req_addr_d = interface2mem_address;
                    req_data_d = interface2mem_data;
                    cnt_d      = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = ST_RESPOND;
                        fire    = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESPOND;
                    fire    = 1'b1;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        msg_d       = fire ? C_MEM_RESP : C_NO_REQ;
        resp_addr_d = fire ? cur_addr : '0;
        resp_rd_d   = fire && !cur_write;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            op_write_q  <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            msg_q       <= C_NO_REQ;
            resp_addr_q <= '0;
            resp_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            msg_q       <= msg_d;
            resp_addr_q <= resp_addr_d;
            resp_rd_q   <= resp_rd_d;
        end
    end

    // Gating the enable with reset keeps an aborted write from landing.
    single_port_word_ram #(
        .INDEX_BITS (INDEX_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clock),
        .en    (fire && reset),
        .we    (cur_write),
        .addr  (cur_addr[INDEX_BITS-1:0]),
        .wdata (cur_data),
        .rdata (ram_rdata)
    );

    assign mem2interface_msg     = msg_q;
    assign mem2interface_address = resp_addr_q;
    assign mem2interface_data    = resp_rd_q ? ram_rdata : '0;

endmodule

// File: tb/tb_main_memory_responder.sv
// tb/tb_main_memory_responder.sv - scoreboard bench for main_memory_responder at LATENCY 3 and 1
module tb_main_memory_responder;
    import main_memory_responder_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i3_msg, i1_msg, o3_msg, o1_msg;
    logic [31:0] i3_addr, i3_data, i1_addr, i1_data;
    logic [31:0] o3_addr, o3_data, o1_addr, o1_data;

    int          tests_run = 0;
    int          tests_failed = 0;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    main_memory_responder #(.LATENCY(3)) u_dut3 (
        .clock(clk), .reset(rst_n),
        .interface2mem_msg(i3_msg), .interface2mem_address(i3_addr), .interface2mem_data(i3_data),
        .mem2interface_msg(o3_msg), .mem2interface_address(o3_addr), .mem2interface_data(o3_data)
    );

    main_memory_responder #(.LATENCY(1)) u_dut1 (
        .clock(clk), .reset(rst_n),
        .interface2mem_msg(i1_msg), .interface2mem_address(i1_addr), .interface2mem_data(i1_data),
        .mem2interface_msg(o1_msg), .mem2interface_address(o1_addr), .mem2interface_data(o1_data)
    );

    task automatic drive(input int sel, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        if (sel == 1) begin
            i1_msg = m; i1_addr = a; i1_data = d;
        end else begin
            i3_msg = m; i3_addr = a; i3_data = d;
        end
    endtask

    task automatic idle(input int sel);
        drive(sel, NO_REQ, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic wait_resp(input int sel, input int limit, output bit seen, output int lat,
                             output logic [31:0] ra, output logic [31:0] rd);
        seen = 1'b0; lat = 0; ra = 'x; rd = 'x;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (((sel == 1) ? o1_msg : o3_msg) == MEM_RESP) begin
                seen = 1'b1;
                lat  = k;
                ra   = (sel == 1) ? o1_addr : o3_addr;
                rd   = (sel == 1) ? o1_data : o3_data;
                break;
            end
        end
    endtask

    // Drives a request, records the expected response, waits for MEM_RESP and pops the scoreboard.
    task automatic run_req(input int sel, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d,
                           output bit seen, output int lat, output logic [31:0] ra, output logic [31:0] rd,
                           output logic [31:0] ea, output logic [31:0] ed);
        exp_t e;
        int   key;
        key = sel * 1024 + int'(a[9:0]);
        e.addr = a;
        e.data = (m == R_REQ) ? ref_mem[key] : 32'h0;
        if (m == WB_REQ) ref_mem[key] = d;
        exp_q.push_back(e);
        drive(sel, m, a, d);
        wait_resp(sel, 40, seen, lat, ra, rd);
        e  = exp_q.pop_front();
        ea = e.addr;
        ed = e.data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(3, NO_REQ, 32'h0, 32'h0);
        drive(1, NO_REQ, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({o3_msg, o3_addr, o3_data, o1_msg, o1_addr, o1_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h/%h/%h %h/%h/%h expected all zero",
                     o3_msg, o3_addr, o3_data, o1_msg, o1_addr, o1_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if ({o3_msg, o3_addr, o3_data} !== '0) begin
                tests_failed++;
                $display("FAIL idle_l3 cycle %0d: got %h/%h/%h expected 0/0/0", i, o3_msg, o3_addr, o3_data);
            end
            tests_run++;
            if ({o1_msg, o1_addr, o1_data} !== '0) begin
                tests_failed++;
                $display("FAIL idle_l1 cycle %0d: got %h/%h/%h expected 0/0/0", i, o1_msg, o1_addr, o1_data);
            end
        end
    endtask

    task automatic test_write_read;
        logic [3:0]  ops [2]  = '{WB_REQ, R_REQ};
        bit seen; int lat; logic [31:0] ra, rd, ea, ed;
        for (int i = 0; i < 2; i++) begin
            run_req(3, ops[i], 32'h10, 32'hDEADBEEF, seen, lat, ra, rd, ea, ed);
            tests_run++;
            if (!seen || lat != 3) begin
                tests_failed++;
                $display("FAIL wr_rd_latency op %0d: got %0d (seen %0b) expected 3", i, lat, seen);
            end
            tests_run++;
            if (ra !== ea || rd !== ed) begin
                tests_failed++;
                $display("FAIL wr_rd_resp op %0d: got addr %h data %h expected addr %h data %h", i, ra, rd, ea, ed);
            end
            idle(3);
        end
    endtask

    task automatic test_line_read;
        bit seen; int lat; int dup; logic [31:0] ra, rd, ea, ed;
        for (int i = 0; i < 4; i++) begin
            run_req(3, WB_REQ, 32'h40 + i, 32'h1 + i, seen, lat, ra, rd, ea, ed);
            idle(3);
        end
        // Address advances during RESPOND with R_REQ held, as the cache interface does.
        for (int i = 0; i < 4; i++) begin
            run_req(3, R_REQ, 32'h40 + i, 32'h0, seen, lat, ra, rd, ea, ed);
            tests_run++;
            if (!seen || lat != ((i == 0) ? 3 : 4)) begin
                tests_failed++;
                $display("FAIL line_latency word %0d: got %0d (seen %0b) expected %0d", i, lat, seen, (i == 0) ? 3 : 4);
            end
            tests_run++;
            if (ra !== ea || rd !== ed) begin
                tests_failed++;
                $display("FAIL line_resp word %0d: got addr %h data %h expected addr %h data %h", i, ra, rd, ea, ed);
            end
        end
        drive(3, NO_REQ, 32'h0, 32'h0);
        dup = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o3_msg == MEM_RESP) dup++;
        end
        tests_run++;
        if (dup != 0) begin
            tests_failed++;
            $display("FAIL line_duplicate: got %0d extra responses expected 0", dup);
        end
    endtask

    task automatic test_back_to_back;
        bit seen; int lat; logic [31:0] ra, rd, ea, ed;
        for (int i = 0; i < 3; i++) begin
            run_req(1, WB_REQ, 32'h80 + i, 32'hC0DE_0000 + i, seen, lat, ra, rd, ea, ed);
            tests_run++;
            if (!seen || lat != ((i == 0) ? 1 : 2)) begin
                tests_failed++;
                $display("FAIL b2b_write_latency %0d: got %0d (seen %0b) expected %0d", i, lat, seen, (i == 0) ? 1 : 2);
            end
        end
        for (int i = 0; i < 3; i++) begin
            run_req(1, R_REQ, 32'h82 - i, 32'h0, seen, lat, ra, rd, ea, ed);
            tests_run++;
            if (!seen || lat != 2) begin
                tests_failed++;
                $display("FAIL b2b_read_latency %0d: got %0d (seen %0b) expected 2", i, lat, seen);
            end
            tests_run++;
            if (ra !== ea || rd !== ed) begin
                tests_failed++;
                $display("FAIL b2b_read_resp %0d: got addr %h data %h expected addr %h data %h", i, ra, rd, ea, ed);
            end
        end
        idle(1);
    endtask

    task automatic test_reset_abort;
        bit seen; int lat; int hits; logic [31:0] ra, rd, ea, ed;
        run_req(3, WB_REQ, 32'h20, 32'h11, seen, lat, ra, rd, ea, ed);
        idle(3);
        drive(3, WB_REQ, 32'h20, 32'h55);
        @(negedge clk);
        tests_run++;
        if (o3_msg !== NO_REQ) begin
            tests_failed++;
            $display("FAIL abort_busy_msg: got %h expected %h", o3_msg, NO_REQ);
        end
        rst_n = 1'b0;
        drive(3, NO_REQ, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o3_msg == MEM_RESP) hits++;
        end
        tests_run++;
        if (hits != 0) begin
            tests_failed++;
            $display("FAIL abort_no_resp: got %0d responses expected 0", hits);
        end
        run_req(3, R_REQ, 32'h20, 32'h0, seen, lat, ra, rd, ea, ed);
        tests_run++;
        if (!seen || rd !== ed || ra !== ea) begin
            tests_failed++;
            $display("FAIL abort_read: got addr %h data %h (seen %0b) expected addr %h data %h", ra, rd, seen, ea, ed);
        end
        idle(3);
    endtask

    task automatic test_ignore_alias;
        logic [3:0] codes [2] = '{FLUSH, 4'hA};
        bit seen; int lat; int hits; logic [31:0] ra, rd, ea, ed;
        for (int c = 0; c < 2; c++) begin
            drive(3, codes[c], 32'h10, 32'h1234);
            hits = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (o3_msg == MEM_RESP) hits++;
            end
            tests_run++;
            if (hits != 0) begin
                tests_failed++;
                $display("FAIL ignore_code %h: got %0d responses expected 0", codes[c], hits);
            end
        end
        idle(3);
        run_req(3, WB_REQ, 32'h410, 32'hA5A5_0410, seen, lat, ra, rd, ea, ed);
        tests_run++;
        if (!seen || ra !== ea || rd !== ed) begin
            tests_failed++;
            $display("FAIL alias_write: got addr %h data %h (seen %0b) expected addr %h data %h", ra, rd, seen, ea, ed);
        end
        idle(3);
        run_req(3, R_REQ, 32'h010, 32'h0, seen, lat, ra, rd, ea, ed);
        tests_run++;
        if (!seen || ra !== ea || rd !== ed) begin
            tests_failed++;
            $display("FAIL alias_read: got addr %h data %h (seen %0b) expected addr %h data %h", ra, rd, seen, ea, ed);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_line_read();
        test_back_to_back();
        test_reset_abort();
        test_ignore_alias();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
